// File: rtl/hex_pkg.sv
// Shared constants and FSM state type for the multiplexed hex display scanner.
package hex_pkg;

  localparam logic [31:0] DIGIT_OFF_N = '1;
  localparam logic [3:0]  NIB_BLANK   = 4'h0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_tick.sv
// Prescale counter: wraps every PRESCALE enabled cycles and flags the last one as tick_o.
module scan_tick #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned    CntW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Round-robin two-requester arbiter that latches the winner's value and scans it across
// common-anode digits, one digit every PRESCALE cycles.
module hex_scan_ctrl #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned NDIG     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [4*NDIG-1:0] data_a,
  input  logic              req_b,
  input  logic [4*NDIG-1:0] data_b,
  output logic              grant_a,
  output logic              grant_b,
  output logic [3:0]        nib,
  output logic [NDIG-1:0]   digit_en_n,
  output logic              frame_done
);
  import hex_pkg::*;

  localparam int unsigned DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  scan_state_e       state_q, state_d;
  logic              grant_a_q, grant_a_d;
  logic              grant_b_q, grant_b_d;
  logic              prio_b_q, prio_b_d;  // set when A was served last
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [DW-1:0]     d_q, d_d;
  logic [3:0]        nib_q, nib_d;
  logic [NDIG-1:0]   den_q, den_d;

  logic tick, frame_end, arb, win_a, win_b;

  scan_tick #(
    .PRESCALE(PRESCALE)
  ) u_scan_tick (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (state_q == SCAN),
    .clr_i (arb),
    .tick_o(tick)
  );

  assign frame_end = (state_q == SCAN) && tick && (d_q == DW'(NDIG - 1));
  assign arb       = (state_q == IDLE) || frame_end;
  assign win_a     = req_a && (!req_b || !prio_b_q);
  assign win_b     = req_b && (!req_a || prio_b_q);

  always_comb begin
    state_d   = state_q;
    grant_a_d = grant_a_q;
    grant_b_d = grant_b_q;
    prio_b_d  = prio_b_q;
    shadow_d  = shadow_q;
    d_d       = d_q;

    if (arb) begin
      d_d = '0;
      if (win_a) begin
        state_d   = SCAN;
        grant_a_d = 1'b1;
        grant_b_d = 1'b0;
        prio_b_d  = 1'b1;
        shadow_d  = data_a;
      end else if (win_b) begin
        state_d   = SCAN;
        grant_a_d = 1'b0;
        grant_b_d = 1'b1;
        prio_b_d  = 1'b0;
        shadow_d  = data_b;
      end else begin
        state_d   = IDLE;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
      end
    end else if (tick) begin
      d_d = d_q + DW'(1);
    end

    // Outputs are registered from next-state values so they change on the same edge as d.
    if (state_d == SCAN) begin
      nib_d = shadow_d[4*int'(d_d) +: 4];
      den_d = ~(NDIG'(1) << d_d);
    end else begin
      nib_d = NIB_BLANK;
      den_d = DIGIT_OFF_N[NDIG-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      prio_b_q  <= 1'b0;
      shadow_q  <= '0;
      d_q       <= '0;
      nib_q     <= NIB_BLANK;
      den_q     <= DIGIT_OFF_N[NDIG-1:0];
    end else begin
      state_q   <= state_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      prio_b_q  <= prio_b_d;
      shadow_q  <= shadow_d;
      d_q       <= d_d;
      nib_q     <= nib_d;
      den_q     <= den_d;
    end
  end

  assign grant_a    = grant_a_q;
  assign grant_b    = grant_b_q;
  assign nib        = nib_q;
  assign digit_en_n = den_q;
  assign frame_done = frame_end;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench: arbitration, refresh, idle return, async reset, and a PRESCALE=1 build.
module tb_hex_scan_ctrl;

  logic        clk;
  logic        reset, reset1;
  logic        req_a, req_b, req_a1;
  logic [15:0] data_a, data_b, data_a1;
  logic        grant_a, grant_b, frame_done;
  logic [3:0]  nib, digit_en_n;
  logic        grant_a1, grant_b1, frame_done1;
  logic [3:0]  nib1, digit_en_n1;

  int n_vec = 0;
  int n_err = 0;

  hex_scan_ctrl #(
    .PRESCALE(4),
    .NDIG    (4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .nib       (nib),
    .digit_en_n(digit_en_n),
    .frame_done(frame_done)
  );

  hex_scan_ctrl #(
    .PRESCALE(1),
    .NDIG    (4)
  ) u_dut_p1 (
    .clk       (clk),
    .reset     (reset1),
    .req_a     (req_a1),
    .data_a    (data_a1),
    .req_b     (1'b0),
    .data_b    (16'h0000),
    .grant_a   (grant_a1),
    .grant_b   (grant_b1),
    .nib       (nib1),
    .digit_en_n(digit_en_n1),
    .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check_eq({name, " grant_a"}, 32'(grant_a), 32'd0);
    check_eq({name, " grant_b"}, 32'(grant_b), 32'd0);
    check_eq({name, " digit_en_n"}, 32'(digit_en_n), 32'hF);
    check_eq({name, " nib"}, 32'(nib), 32'd0);
    check_eq({name, " frame_done"}, 32'(frame_done), 32'd0);
  endtask

  // Checks one 16-cycle frame; at cycle act the inputs are changed to the *_n values.
  task automatic run_frame(input string name, input logic ga, input logic gb,
                           input logic [15:0] val, input int act,
                           input logic ra_n, input logic rb_n,
                           input logic [15:0] da_n, input logic [15:0] db_n);
    logic [15:0] v;
    logic [3:0]  den_exp;
    v = val;
    for (int i = 0; i < 16; i++) begin
      int d;
      d = i / 4;
      den_exp = ~(4'b0001 << d);
      step();
      check_eq($sformatf("%s c%0d grant_a", name, i), 32'(grant_a), 32'(ga));
      check_eq($sformatf("%s c%0d grant_b", name, i), 32'(grant_b), 32'(gb));
      check_eq($sformatf("%s c%0d digit_en_n", name, i), 32'(digit_en_n), 32'(den_exp));
      check_eq($sformatf("%s c%0d nib", name, i), 32'(nib), 32'(v[4*d +: 4]));
      check_eq($sformatf("%s c%0d frame_done", name, i), 32'(frame_done), 32'(i == 15));
      if (i == act) begin
        req_a  = ra_n;
        req_b  = rb_n;
        data_a = da_n;
        data_b = db_n;
      end
    end
  endtask

  initial begin
    logic [15:0] v1;
    logic [3:0]  den1_exp;

    reset   = 1'b1;
    reset1  = 1'b1;
    req_a   = 1'b0;
    req_b   = 1'b0;
    data_a  = 16'h0;
    data_b  = 16'h0;
    req_a1  = 1'b0;
    data_a1 = 16'h0;
    repeat (2) step();
    check_idle("reset");

    // Single requester, then refresh with new data and finally a drop back to idle.
    reset  = 1'b0;
    req_a  = 1'b1;
    data_a = 16'h1234;
    run_frame("a1", 1'b1, 1'b0, 16'h1234, -1, 1'b1, 1'b0, 16'h1234, 16'h0);
    run_frame("a2", 1'b1, 1'b0, 16'h1234, 5, 1'b1, 1'b0, 16'h00C0, 16'h0);
    run_frame("a3", 1'b1, 1'b0, 16'h00C0, 5, 1'b1, 1'b0, 16'h1234, 16'h0);
    run_frame("a4", 1'b1, 1'b0, 16'h1234, 5, 1'b0, 1'b0, 16'hFFFF, 16'h0);
    step();
    check_idle("idle0");
    step();
    check_idle("idle1");

    // Async reset mid-frame must clear outputs without a clock edge.
    req_a  = 1'b1;
    data_a = 16'hAAAA;
    repeat (9) step();
    check_eq("pre-reset grant_a", 32'(grant_a), 32'd1);
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    req_a  = 1'b0;
    req_b  = 1'b1;
    data_b = 16'h5555;
    repeat (2) step();
    check_idle("held_reset");
    reset = 1'b0;

    // B alone, then both held: grants alternate A, B, A.
    run_frame("b1", 1'b0, 1'b1, 16'h5555, 3, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    run_frame("a5", 1'b1, 1'b0, 16'hAAAA, -1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    run_frame("b2", 1'b0, 1'b1, 16'h5555, -1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);
    run_frame("a6", 1'b1, 1'b0, 16'hAAAA, -1, 1'b1, 1'b1, 16'hAAAA, 16'h5555);

    // A was served last, but reset restores A-first priority.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
    check_eq("rr_reset grant_a", 32'(grant_a), 32'd1);
    check_eq("rr_reset grant_b", 32'(grant_b), 32'd0);
    check_eq("rr_reset nib", 32'(nib), 32'hA);
    check_eq("rr_reset digit_en_n", 32'(digit_en_n), 32'hE);
    req_a = 1'b0;
    req_b = 1'b0;

    // PRESCALE=1 build: one digit per cycle.
    reset1  = 1'b0;
    req_a1  = 1'b1;
    data_a1 = 16'h9876;
    v1 = 16'h9876;
    for (int i = 0; i < 8; i++) begin
      int d;
      d = i % 4;
      den1_exp = ~(4'b0001 << d);
      step();
      check_eq($sformatf("p1 c%0d grant_a", i), 32'(grant_a1), 32'd1);
      check_eq($sformatf("p1 c%0d nib", i), 32'(nib1), 32'(v1[4*d +: 4]));
      check_eq($sformatf("p1 c%0d digit_en_n", i), 32'(digit_en_n1), 32'(den1_exp));
      check_eq($sformatf("p1 c%0d frame_done", i), 32'(frame_done1), 32'(d == 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
